rvm_test_monitor: RTL and testbench
===================================

Name: rvm_test_monitor

Overview:
Synthesizable test-completion monitor for rvm_core simulation and FPGA bring-up. Snoops the core memory bus and compares accepted addresses against NUM_WATCH programmable watchpoints, each tagged HALT, PASS or FAIL. Counts cycles, applies an optional timeout and latches a sticky result code, hit index and cycle count. The bench or a debug register block reads these results, so the run outcome is decided in one place.

Parameters:
ADDR_W, 32, memory address width.
NUM_WATCH, 4, number of watchpoints (1..16).
IDX_W, 2, width of hit_index; must be >= clog2(NUM_WATCH), minimum 1.
CNT_W, 32, cycle counter width.

Ports:
clk  input  1  core clock; all state updates on rising edge.
resetn  input  1  asynchronous active-low reset.
start  input  1  begin a run; sampled in IDLE or DONE.
clear  input  1  return to IDLE from any state; wins over start.
mem_addr  input  ADDR_W  core memory address.
mem_c_en  input  1  core memory chip enable.
mem_stall  input  1  memory stall indicator.
watch_en  input  NUM_WATCH  per-watchpoint enable.
watch_addr  input  NUM_WATCH*ADDR_W  watch addresses; entry i is at bits [i*ADDR_W +: ADDR_W].
watch_kind  input  NUM_WATCH*2  per-watchpoint kind: 00 HALT, 01 PASS, 10 FAIL, 11 FAIL.
max_cycles  input  CNT_W  timeout limit; 0 disables the timeout.
busy  output  1  high in RUN.
done  output  1  high in DONE.
done_pulse  output  1  one-cycle pulse on entry to DONE.
result  output  3  0 NONE, 1 PASS, 2 FAIL, 3 HALT, 4 TIMEOUT.
hit_index  output  IDX_W  index of the watchpoint that ended the run; 0 on timeout.
cycle_count  output  CNT_W  number of RUN cycles elapsed.

Behaviour:
- Reset (resetn low, asynchronous): state IDLE; busy=0, done=0, done_pulse=0, result=0, hit_index=0, cycle_count=0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 → RUN at the next edge; cycle_count<=0; result<=0.
- Hit qualification, evaluated in RUN:
  - hit_i = watch_en[i] & mem_c_en & ~mem_stall & (mem_addr == watch_addr_i).
  - A stalled or disabled bus cycle never hits.
  - Multiple simultaneous hits: the lowest index wins.
- Each RUN cycle:
  - cycle_count <= cycle_count+1, saturating at all-ones.
  - If any hit: → DONE; result from the winning watchpoint's kind; hit_index <= winning index.
  - Else if max_cycles != 0 and cycle_count+1 == max_cycles: → DONE; result=TIMEOUT; hit_index=0.
  - A hit and the timeout in the same cycle: the hit wins.
- Latency: detection is registered. done and done_pulse rise one edge after the hit cycle.
- cycle_count at DONE includes the terminating cycle.
- DONE:
  - Outputs hold (sticky); done_pulse drops after one cycle.
  - start=1 → RUN with counters and result cleared. done_pulse does not fire again until the next DONE entry.
- clear=1 in any state → IDLE at the next edge. result, hit_index and cycle_count are cleared to 0. clear has priority over start, hits and timeout.
- Config inputs (watch_*, max_cycles) are sampled live every cycle. Changing them mid-RUN takes effect immediately.
- Asynchronous reset mid-RUN aborts the run immediately; there is no partial result.
- max_cycles=0 with no hits: RUN continues indefinitely; cycle_count saturates and does not wrap.

Test Plan:
- Reset then start; PASS watchpoint 0 at 0x100; drive mem_addr=0x100, c_en=1 on the 3rd RUN cycle → done_pulse one edge later; result=1, hit_index=0, cycle_count=3.
- Watch 1 FAIL at 0x200 and watch 2 HALT at 0x200, both enabled; accepted access to 0x200 → result=2, hit_index=1.
- Access to the PASS address 0x100 with mem_stall=1 for 4 cycles, then stall=0 → no hit while stalled; hit on the stall-release cycle; cycle_count reflects that cycle.
- max_cycles=5, no hits → done after 5 RUN cycles; result=4, cycle_count=5, hit_index=0. Repeat with a hit on cycle 5 → result from the watchpoint, not 4.
- In DONE, pulse start → busy=1, cycle_count restarts at 0, done_pulse fires exactly once per run. Pulse clear together with start → IDLE with all outputs 0.
- Assert resetn=0 asynchronously mid-RUN (between clock edges) → all outputs 0 immediately. CNT_W=4, max_cycles=0 → cycle_count saturates at 15.

Source files
------------

// File: rtl/rvm_test_monitor.sv
// Test-completion monitor: snoops accepted bus addresses against tagged watchpoints,
// applies an optional cycle timeout and latches a sticky result, hit index and cycle count.
module rvm_test_monitor #(
  parameter int ADDR_W    = 32,
  parameter int NUM_WATCH = 4,
  parameter int IDX_W     = 2,
  parameter int CNT_W     = 32
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  input  logic                        clear,
  input  logic [ADDR_W-1:0]           mem_addr,
  input  logic                        mem_c_en,
  input  logic                        mem_stall,
  input  logic [NUM_WATCH-1:0]        watch_en,
  input  logic [NUM_WATCH*ADDR_W-1:0] watch_addr,
  input  logic [NUM_WATCH*2-1:0]      watch_kind,
  input  logic [CNT_W-1:0]            max_cycles,
  output logic                        busy,
  output logic                        done,
  output logic                        done_pulse,
  output logic [2:0]                  result,
  output logic [IDX_W-1:0]            hit_index,
  output logic [CNT_W-1:0]            cycle_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] RES_NONE    = 3'd0;
  localparam logic [2:0] RES_PASS    = 3'd1;
  localparam logic [2:0] RES_FAIL    = 3'd2;
  localparam logic [2:0] RES_HALT    = 3'd3;
  localparam logic [2:0] RES_TIMEOUT = 3'd4;

  state_t                 state_r, state_s;
  logic                   busy_r, done_r, done_pulse_r, done_pulse_s;
  logic [2:0]             result_r, result_s;
  logic [IDX_W-1:0]       hit_index_r, hit_index_s;
  logic [CNT_W-1:0]       cycle_count_r, cycle_count_s, count_inc_s;
  logic [NUM_WATCH-1:0]   match_s;
  logic                   hit_any_s, timeout_s;
  logic [IDX_W-1:0]       hit_idx_s;
  logic [1:0]             hit_kind_s;

  function automatic logic [2:0] kind_to_result(input logic [1:0] kind);
    case (kind)
      2'b00:   kind_to_result = RES_HALT;
      2'b01:   kind_to_result = RES_PASS;
      default: kind_to_result = RES_FAIL;
    endcase
  endfunction

  // Per-watchpoint match and lowest-index priority selection; stalled or idle bus never hits.
  always_comb begin
    match_s    = {NUM_WATCH{1'b0}};
    hit_idx_s  = {IDX_W{1'b0}};
    hit_kind_s = 2'b00;
    for (int i = 0; i < NUM_WATCH; i++) begin
      match_s[i] = watch_en[i] & mem_c_en & ~mem_stall &
                   (mem_addr == watch_addr[i*ADDR_W +: ADDR_W]);
    end
    for (int i = NUM_WATCH - 1; i >= 0; i--) begin
      hit_idx_s  = match_s[i] ? IDX_W'(i) : hit_idx_s;
      hit_kind_s = match_s[i] ? watch_kind[i*2 +: 2] : hit_kind_s;
    end
    hit_any_s = |match_s;
  end

  // Saturating increment and timeout detection against the live limit.
  always_comb begin
    count_inc_s = (&cycle_count_r) ? cycle_count_r : cycle_count_r + CNT_W'(1);
    timeout_s   = (max_cycles != {CNT_W{1'b0}}) &&
                  ((cycle_count_r + CNT_W'(1)) == max_cycles);
  end

  // Next-state logic; clear overrides everything.
  always_comb begin
    state_s = state_r;
    if (clear) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_s = start ? ST_RUN : ST_IDLE;
        ST_RUN:  state_s = (hit_any_s || timeout_s) ? ST_DONE : ST_RUN;
        ST_DONE: state_s = start ? ST_RUN : ST_DONE;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Next values of the latched run results.
  always_comb begin
    result_s      = result_r;
    hit_index_s   = hit_index_r;
    cycle_count_s = cycle_count_r;
    done_pulse_s  = 1'b0;
    if (clear) begin
      result_s      = RES_NONE;
      hit_index_s   = {IDX_W{1'b0}};
      cycle_count_s = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            result_s      = RES_NONE;
            hit_index_s   = {IDX_W{1'b0}};
            cycle_count_s = {CNT_W{1'b0}};
          end else begin
            result_s      = result_r;
          end
        end
        ST_RUN: begin
          cycle_count_s = count_inc_s;
          if (hit_any_s) begin
            result_s     = kind_to_result(hit_kind_s);
            hit_index_s  = hit_idx_s;
            done_pulse_s = 1'b1;
          end else if (timeout_s) begin
            result_s     = RES_TIMEOUT;
            hit_index_s  = {IDX_W{1'b0}};
            done_pulse_s = 1'b1;
          end else begin
            result_s     = result_r;
          end
        end
        default: begin
          result_s      = RES_NONE;
          hit_index_s   = {IDX_W{1'b0}};
          cycle_count_s = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r       <= ST_IDLE;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      done_pulse_r  <= 1'b0;
      result_r      <= RES_NONE;
      hit_index_r   <= {IDX_W{1'b0}};
      cycle_count_r <= {CNT_W{1'b0}};
    end else begin
      state_r       <= state_s;
      busy_r        <= (state_s == ST_RUN);
      done_r        <= (state_s == ST_DONE);
      done_pulse_r  <= done_pulse_s;
      result_r      <= result_s;
      hit_index_r   <= hit_index_s;
      cycle_count_r <= cycle_count_s;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign done_pulse  = done_pulse_r;
  assign result      = result_r;
  assign hit_index   = hit_index_r;
  assign cycle_count = cycle_count_r;

endmodule

// File: tb/tb_rvm_test_monitor.sv
// Self-checking bench for rvm_test_monitor: directed scenarios plus randomized runs scored
// against a run-level model that scans the bus trace for the first terminating cycle.
module tb_rvm_test_monitor;

  localparam int ADDR_W    = 32;
  localparam int NUM_WATCH = 4;
  localparam int IDX_W     = 2;
  localparam int CNT_W     = 32;

  logic                        clk = 1'b0;
  logic                        resetn, start, clear, mem_c_en, mem_stall;
  logic [ADDR_W-1:0]           mem_addr;
  logic [NUM_WATCH-1:0]        watch_en;
  logic [NUM_WATCH*ADDR_W-1:0] watch_addr;
  logic [NUM_WATCH*2-1:0]      watch_kind;
  logic [CNT_W-1:0]            max_cycles;
  logic                        busy, done, done_pulse;
  logic [2:0]                  result;
  logic [IDX_W-1:0]            hit_index;
  logic [CNT_W-1:0]            cycle_count;

  logic [3:0]                  s_max_cycles = 4'd0;
  logic                        s_busy, s_done, s_done_pulse;
  logic [2:0]                  s_result;
  logic [IDX_W-1:0]            s_hit_index;
  logic [3:0]                  s_cycle_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] bus_addr  [32];
  logic        bus_cen   [32];
  logic        bus_stall [32];
  logic [31:0] pool      [4] = '{32'h100, 32'h200, 32'h300, 32'h400};
  int          res_of_kind [4] = '{3, 1, 2, 2};

  rvm_test_monitor #(.ADDR_W(ADDR_W), .NUM_WATCH(NUM_WATCH), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .resetn(resetn), .start(start), .clear(clear),
    .mem_addr(mem_addr), .mem_c_en(mem_c_en), .mem_stall(mem_stall),
    .watch_en(watch_en), .watch_addr(watch_addr), .watch_kind(watch_kind),
    .max_cycles(max_cycles), .busy(busy), .done(done), .done_pulse(done_pulse),
    .result(result), .hit_index(hit_index), .cycle_count(cycle_count)
  );

  rvm_test_monitor #(.ADDR_W(ADDR_W), .NUM_WATCH(NUM_WATCH), .IDX_W(IDX_W), .CNT_W(4)) u_sat (
    .clk(clk), .resetn(resetn), .start(start), .clear(clear),
    .mem_addr(mem_addr), .mem_c_en(mem_c_en), .mem_stall(mem_stall),
    .watch_en(watch_en), .watch_addr(watch_addr), .watch_kind(watch_kind),
    .max_cycles(s_max_cycles), .busy(s_busy), .done(s_done), .done_pulse(s_done_pulse),
    .result(s_result), .hit_index(s_hit_index), .cycle_count(s_cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bus();
    for (int i = 0; i < 32; i++) begin
      bus_addr[i]  = 32'h0;
      bus_cen[i]   = 1'b0;
      bus_stall[i] = 1'b0;
    end
  endtask

  task automatic set_watch(input int i, input logic en, input logic [31:0] a, input logic [1:0] k);
    watch_en[i]          = en;
    watch_addr[i*32 +: 32] = a;
    watch_kind[i*2 +: 2] = k;
  endtask

  task automatic check_idle(input string tag);
    check_value({tag, "_busy"},  64'(busy), 64'd0);
    check_value({tag, "_done"},  64'(done), 64'd0);
    check_value({tag, "_pulse"}, 64'(done_pulse), 64'd0);
    check_value({tag, "_res"},   64'(result), 64'd0);
    check_value({tag, "_idx"},   64'(hit_index), 64'd0);
    check_value({tag, "_cnt"},   64'(cycle_count), 64'd0);
  endtask

  task automatic do_clear(input string tag);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_idle(tag);
  endtask

  // Model: the run ends at the first cycle with a qualifying hit (lowest index) or at the timeout.
  task automatic execute_run(input string tag, input int len, output int end_k,
                             output logic [2:0] exp_res, output logic [1:0] exp_idx);
    int hit;
    bit finished;
    end_k = 0; exp_res = 3'd0; exp_idx = 2'd0;
    for (int k = 1; k <= len; k++) begin
      if (end_k == 0) begin
        hit = -1;
        for (int i = NUM_WATCH - 1; i >= 0; i--)
          if (watch_en[i] && bus_cen[k-1] && !bus_stall[k-1] &&
              bus_addr[k-1] == watch_addr[i*32 +: 32]) hit = i;
        if (hit >= 0) begin
          end_k = k; exp_res = 3'(res_of_kind[watch_kind[hit*2 +: 2]]); exp_idx = 2'(hit);
        end else if (max_cycles != 32'd0 && max_cycles == 32'(k)) begin
          end_k = k; exp_res = 3'd4; exp_idx = 2'd0;
        end
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check_value({tag, "_start_busy"}, 64'(busy), 64'd1);
    check_value({tag, "_start_done"}, 64'(done), 64'd0);
    check_value({tag, "_start_cnt"},  64'(cycle_count), 64'd0);
    finished = 1'b0;
    for (int k = 1; k <= len; k++) begin
      if (!finished) begin
        mem_addr  = bus_addr[k-1];
        mem_c_en  = bus_cen[k-1];
        mem_stall = bus_stall[k-1];
        tick();
        if (k == end_k) begin
          check_value({tag, "_end_done"},  64'(done), 64'd1);
          check_value({tag, "_end_busy"},  64'(busy), 64'd0);
          check_value({tag, "_end_pulse"}, 64'(done_pulse), 64'd1);
          check_value({tag, "_end_res"},   64'(result), 64'(exp_res));
          check_value({tag, "_end_idx"},   64'(hit_index), 64'(exp_idx));
          check_value({tag, "_end_cnt"},   64'(cycle_count), 64'(k));
          mem_c_en = 1'b0; mem_stall = 1'b0;
          tick();
          check_value({tag, "_hold_pulse"}, 64'(done_pulse), 64'd0);
          check_value({tag, "_hold_done"},  64'(done), 64'd1);
          check_value({tag, "_hold_res"},   64'(result), 64'(exp_res));
          check_value({tag, "_hold_cnt"},   64'(cycle_count), 64'(k));
          finished = 1'b1;
        end else begin
          check_value({tag, "_run_busy"},  64'(busy), 64'd1);
          check_value({tag, "_run_pulse"}, 64'(done_pulse), 64'd0);
          check_value({tag, "_run_cnt"},   64'(cycle_count), 64'(k));
        end
      end
    end
    mem_c_en = 1'b0; mem_stall = 1'b0;
  endtask

  initial begin
    int          end_k;
    logic [2:0]  er;
    logic [1:0]  ei;
    int          r;
    resetn = 1'b0; start = 1'b0; clear = 1'b0;
    mem_addr = 32'h0; mem_c_en = 1'b0; mem_stall = 1'b0;
    watch_en = '0; watch_addr = '0; watch_kind = '0; max_cycles = 32'd0;
    #12;
    check_idle("reset");
    resetn = 1'b1;
    tick();
    check_idle("post_reset");

    // PASS watchpoint hit on the third RUN cycle
    clear_bus();
    set_watch(0, 1'b1, 32'h100, 2'b01);
    bus_addr[2] = 32'h100; bus_cen[2] = 1'b1;
    execute_run("pass3", 6, end_k, er, ei);
    check_value("pass3_res", 64'(result), 64'd1);
    check_value("pass3_idx", 64'(hit_index), 64'd0);
    check_value("pass3_cnt", 64'(cycle_count), 64'd3);

    // Simultaneous FAIL (1) and HALT (2) at the same address: lowest index wins
    clear_bus();
    watch_en = '0;
    set_watch(1, 1'b1, 32'h200, 2'b10);
    set_watch(2, 1'b1, 32'h200, 2'b00);
    bus_addr[0] = 32'h200; bus_cen[0] = 1'b1;
    execute_run("prio", 4, end_k, er, ei);
    check_value("prio_res", 64'(result), 64'd2);
    check_value("prio_idx", 64'(hit_index), 64'd1);

    // Stalled accesses never hit; release on cycle 5
    clear_bus();
    watch_en = '0;
    set_watch(0, 1'b1, 32'h100, 2'b01);
    for (int i = 0; i < 5; i++) begin
      bus_addr[i] = 32'h100; bus_cen[i] = 1'b1; bus_stall[i] = (i < 4);
    end
    execute_run("stall", 8, end_k, er, ei);
    check_value("stall_res", 64'(result), 64'd1);
    check_value("stall_cnt", 64'(cycle_count), 64'd5);

    // Timeout at 5 cycles, then a hit on cycle 5 beats the timeout
    clear_bus();
    watch_en = '0;
    max_cycles = 32'd5;
    execute_run("tmo", 8, end_k, er, ei);
    check_value("tmo_res", 64'(result), 64'd4);
    check_value("tmo_cnt", 64'(cycle_count), 64'd5);
    check_value("tmo_idx", 64'(hit_index), 64'd0);
    set_watch(0, 1'b1, 32'h100, 2'b10);
    bus_addr[4] = 32'h100; bus_cen[4] = 1'b1;
    execute_run("tmo_hit", 8, end_k, er, ei);
    check_value("tmo_hit_res", 64'(result), 64'd2);
    check_value("tmo_hit_cnt", 64'(cycle_count), 64'd5);

    // clear together with start in DONE returns to IDLE
    start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    check_idle("clr_start");
    tick();
    check_idle("clr_stay");

    // Asynchronous reset between edges aborts the run
    watch_en = '0; max_cycles = 32'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check_value("arst_pre_busy", 64'(busy), 64'd1);
    #3 resetn = 1'b0;
    #1;
    check_idle("arst");
    #2 resetn = 1'b1;
    tick();
    check_idle("arst_after");

    // Saturation of a 4-bit counter with no timeout
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check_value("sat_cnt",   64'(s_cycle_count), 64'd15);
    check_value("sat_busy",  64'(s_busy), 64'd1);
    check_value("sat_done",  64'(s_done), 64'd0);
    check_value("sat_pulse", 64'(s_done_pulse), 64'd0);
    check_value("sat_res",   64'(s_result), 64'd0);
    check_value("sat_idx",   64'(s_hit_index), 64'd0);
    check_value("wide_cnt",  64'(cycle_count), 64'd20);
    do_clear("sat_clr");

    // Randomized runs
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NUM_WATCH; i++)
        set_watch(i, 1'($urandom), pool[$urandom_range(0, 3)], 2'($urandom));
      max_cycles = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 30));
      for (int k = 0; k < 32; k++) begin
        r = $urandom_range(0, 4);
        bus_addr[k]  = (r < 4) ? pool[r] : $urandom;
        bus_cen[k]   = ($urandom_range(0, 3) == 0);
        bus_stall[k] = ($urandom_range(0, 3) == 0);
      end
      execute_run("rnd", 24, end_k, er, ei);
      if (end_k == 0 || $urandom_range(0, 3) == 0) do_clear("rnd_clr");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
